fwrisc_exec_ldst: RTL and testbench

Load/store execution sequencer for the fwrisc core; it services instructions with op_type LDST, which the single-cycle execute path cannot complete. It computes the effective address, checks alignment, runs a valid/ready transaction on the data bus, and aligns and extends load data. It writes the result back to the register file and signals completion to the execute sequencer. It adds a configurable misalign trap and a bus timeout that the plain execute path does not have.

---
 rtl/fwrisc_exec_ldst.sv | 212 +++++++++++++++++++++
 tb/tb_fwrisc_exec_ldst.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_exec_ldst.sv
// ---------------------------------------------------------------------------
// fwrisc_exec_ldst
//
// Load/store sequencer for the fwrisc core. It accepts one LDST instruction,
// forms the effective address, checks alignment, runs one valid/ready data-bus
// transaction, then aligns and extends load data and writes it back. It ends
// every instruction with a single-cycle done pulse.
//
// Handshake: dbus_valid is held high, with addr/write/wstb/wdata stable, until
// the first rising clock edge at which dbus_ready is also high. That edge is
// the transfer. dbus_rdata is sampled at that same edge.
//
// Parameters
//   ENABLE_MISALIGN_TRAP 1: trap misaligned accesses (no bus cycle).
//                        0: clear the low address bits and proceed.
//   BUS_TIMEOUT          number of dbus_valid cycles without a response
//                        before the access is aborted (0 = wait forever).
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   req_valid, op, op_a, op_b,
//   op_c, rd                     instruction request (sampled in IDLE only)
//   dbus_*                       data bus master
//   rd_wen, rd_waddr, rd_wdata   register file write port
//   done, misalign, bus_err      completion pulse and its qualifiers
// ---------------------------------------------------------------------------
module fwrisc_exec_ldst #(
    parameter bit ENABLE_MISALIGN_TRAP = 1'b1,
    parameter int BUS_TIMEOUT          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_c,
    input  logic [5:0]  rd,
    output logic        dbus_valid,
    input  logic        dbus_ready,
    output logic        dbus_write,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstb,
    input  logic [31:0] dbus_rdata,
    output logic        rd_wen,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        done,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUS, WB, FIN} state_t;

    // Counter value in the last permitted valid cycle.
    localparam bit          TIMEOUT_EN = (BUS_TIMEOUT != 0);
    localparam logic [15:0] TO_LAST    = TIMEOUT_EN ? 16'(BUS_TIMEOUT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [31:0] ea_q;
    logic [3:0]  op_q;
    logic [31:0] op_b_q;
    logic [5:0]  rd_q;
    logic        mis_q;
    logic        err_q;
    logic [31:0] ld_q;
    logic [15:0] cnt_q;

    // Request-side address decode
    logic [31:0] ea;
    logic [31:0] ea_fix;
    logic        aligned;
    logic        trap;

    always_comb begin
        ea      = op_a + op_c;
        aligned = (op[1:0] == 2'd0) ||
                  (op[1:0] == 2'd1 && !ea[0]) ||
                  (op[1]           && ea[1:0] == 2'b00);
        // Size 3 is reserved and behaves as a word access.
        if (op[1])
            ea_fix = {ea[31:2], 2'b00};
        else if (op[0])
            ea_fix = {ea[31:1], 1'b0};
        else
            ea_fix = ea;
        trap = !aligned && ENABLE_MISALIGN_TRAP;
    end

    logic timeout_hit;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TO_LAST) && !dbus_ready;

    // Load data: move the addressed lane down to bit 0, then extend.
    logic [31:0] shifted;
    logic [31:0] ld_ext;
    always_comb begin
        shifted = dbus_rdata >> {ea_q[1:0], 3'b000};
        case (op_q[1:0])
            2'd0:    ld_ext = {{24{!op_q[3] && shifted[7]}},  shifted[7:0]};
            2'd1:    ld_ext = {{16{!op_q[3] && shifted[15]}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid)
                    state_d = trap ? FIN : BUS;
            end
            BUS: begin
                // A response in the final timeout cycle still completes normally.
                if (dbus_ready)
                    state_d = op_q[2] ? FIN : WB;
                else if (timeout_hit)
                    state_d = FIN;
            end
            WB:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ea_q   <= '0;
            op_q   <= '0;
            op_b_q <= '0;
            rd_q   <= '0;
            mis_q  <= 1'b0;
            err_q  <= 1'b0;
            ld_q   <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req_valid) begin
                        ea_q   <= aligned ? ea : ea_fix;
                        op_q   <= op;
                        op_b_q <= op_b;
                        rd_q   <= rd;
                        mis_q  <= trap;
                        err_q  <= 1'b0;
                    end
                end
                BUS: begin
                    if (dbus_ready) begin
                        if (!op_q[2])
                            ld_q <= ld_ext;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs: driven only while the request is outstanding.
    logic in_bus;
    logic is_store;
    assign in_bus   = (state_q == BUS);
    assign is_store = in_bus && op_q[2];

    always_comb begin
        dbus_valid = in_bus;
        dbus_write = is_store;
        dbus_addr  = in_bus ? {ea_q[31:2], 2'b00} : 32'd0;
        dbus_wstb  = 4'b0000;
        dbus_wdata = 32'd0;
        if (is_store) begin
            case (op_q[1:0])
                2'd0: begin
                    dbus_wstb  = 4'b0001 << ea_q[1:0];
                    dbus_wdata = {4{op_b_q[7:0]}};
                end
                2'd1: begin
                    dbus_wstb  = 4'b0011 << ea_q[1:0];
                    dbus_wdata = {2{op_b_q[15:0]}};
                end
                default: begin
                    dbus_wstb  = 4'b1111;
                    dbus_wdata = op_b_q;
                end
            endcase
        end
    end

    // Write-back and completion
    assign rd_wen   = (state_q == WB) && (rd_q != 6'd0);
    assign rd_waddr = rd_q;
    assign rd_wdata = ld_q;
    assign done     = (state_q == FIN);
    assign misalign = (state_q == FIN) && mis_q;
    assign bus_err  = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_fwrisc_exec_ldst.sv
// ---------------------------------------------------------------------------
// Bench for fwrisc_exec_ldst. Two instances share clock and reset:
//   u0: misalign trap on,  BUS_TIMEOUT = 4
//   u1: misalign trap off, BUS_TIMEOUT = 0 (no timeout)
// Expected bus fields and load results come from an arithmetic reference
// model (access width in bytes, lane = address mod 4, masks and extension).
// ---------------------------------------------------------------------------
module tb_fwrisc_exec_ldst;

    // Clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Per-instance signals, index 0 = u0, 1 = u1
    logic        req_valid  [2];
    logic [3:0]  op         [2];
    logic [31:0] op_a       [2];
    logic [31:0] op_b       [2];
    logic [31:0] op_c       [2];
    logic [5:0]  rd         [2];
    logic        dbus_valid [2];
    logic        dbus_ready [2];
    logic        dbus_write [2];
    logic [31:0] dbus_addr  [2];
    logic [31:0] dbus_wdata [2];
    logic [3:0]  dbus_wstb  [2];
    logic [31:0] dbus_rdata [2];
    logic        rd_wen     [2];
    logic [5:0]  rd_waddr   [2];
    logic [31:0] rd_wdata   [2];
    logic        done       [2];
    logic        misalign   [2];
    logic        bus_err    [2];

    fwrisc_exec_ldst #(.ENABLE_MISALIGN_TRAP(1'b1), .BUS_TIMEOUT(4)) u0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .op(op[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .op_c(op_c[0]), .rd(rd[0]),
        .dbus_valid(dbus_valid[0]), .dbus_ready(dbus_ready[0]),
        .dbus_write(dbus_write[0]), .dbus_addr(dbus_addr[0]),
        .dbus_wdata(dbus_wdata[0]), .dbus_wstb(dbus_wstb[0]),
        .dbus_rdata(dbus_rdata[0]),
        .rd_wen(rd_wen[0]), .rd_waddr(rd_waddr[0]), .rd_wdata(rd_wdata[0]),
        .done(done[0]), .misalign(misalign[0]), .bus_err(bus_err[0])
    );

    fwrisc_exec_ldst #(.ENABLE_MISALIGN_TRAP(1'b0), .BUS_TIMEOUT(0)) u1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .op(op[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .op_c(op_c[1]), .rd(rd[1]),
        .dbus_valid(dbus_valid[1]), .dbus_ready(dbus_ready[1]),
        .dbus_write(dbus_write[1]), .dbus_addr(dbus_addr[1]),
        .dbus_wdata(dbus_wdata[1]), .dbus_wstb(dbus_wstb[1]),
        .dbus_rdata(dbus_rdata[1]),
        .rd_wen(rd_wen[1]), .rd_waddr(rd_waddr[1]), .rd_wdata(rd_wdata[1]),
        .done(done[1]), .misalign(misalign[1]), .bus_err(bus_err[1])
    );

    int checks = 0;
    int errors = 0;

    // Last bus fields seen during a transaction, for directed literal checks
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: plain arithmetic over the access width in bytes.
    function automatic void model(
        input  logic [3:0]  op_i,
        input  logic [31:0] a, b, c, rdata,
        input  bit          trap_en,
        output bit          mis,
        output logic [31:0] addr, wdata, ld,
        output logic [3:0]  stb
    );
        int unsigned n;
        int unsigned off;
        int unsigned lane;
        logic [31:0] ea;
        logic [31:0] mask;
        n    = (op_i[1:0] == 2'd0) ? 1 : (op_i[1:0] == 2'd1) ? 2 : 4;
        ea   = a + c;
        off  = ea % n;
        mis  = (off != 0) && trap_en;
        ea   = ea - off;
        addr = ea & ~32'd3;
        lane = ea % 4;
        stb  = op_i[2] ? 4'(((1 << n) - 1) << lane) : 4'd0;
        for (int i = 0; i < 4; i++)
            wdata[8*i +: 8] = b[8*(i % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        ld   = (rdata >> (8*lane)) & mask;
        if (!op_i[3] && n < 4 && ld[8*n-1])
            ld = ld | ~mask;
    endfunction

    // One full instruction on instance idx. waits = cycles of dbus_valid
    // before ready is given; on u0 waits >= 4 means the response never comes.
    task automatic run_txn(input int idx, input logic [3:0] op_i,
                           input logic [31:0] a, b, c, input logic [5:0] rd_i,
                           input int waits, input logic [31:0] rdata_i);
        bit          mis;
        logic [31:0] e_addr, e_wdata, e_ld;
        logic [3:0]  e_stb;
        int          tmo;
        bit          timed;
        int          last;
        tmo = (idx == 0) ? 4 : 0;
        model(op_i, a, b, c, rdata_i, idx == 0, mis, e_addr, e_wdata, e_ld, e_stb);
        timed = (tmo != 0) && (waits >= tmo);
        last  = timed ? tmo - 1 : waits;

        req_valid[idx] = 1'b1;
        op[idx]   = op_i;
        op_a[idx] = a;
        op_b[idx] = b;
        op_c[idx] = c;
        rd[idx]   = rd_i;
        dbus_rdata[idx] = $urandom;
        step();
        // Scramble request fields: the block must have captured them.
        req_valid[idx] = 1'b0;
        op_a[idx] = $urandom;
        op_b[idx] = $urandom;
        op_c[idx] = $urandom;
        rd[idx]   = 6'($urandom);

        if (mis) begin
            check("trap_valid", 32'(dbus_valid[idx]), 32'd0);
            check("trap_done",  32'(done[idx]),       32'd1);
            check("trap_mis",   32'(misalign[idx]),   32'd1);
            check("trap_err",   32'(bus_err[idx]),    32'd0);
            check("trap_wen",   32'(rd_wen[idx]),     32'd0);
            step();
            check("trap_idle",  32'(done[idx]),       32'd0);
            return;
        end

        for (int k = 0; k <= last; k++) begin
            check("bus_valid", 32'(dbus_valid[idx]), 32'd1);
            check("bus_addr",  dbus_addr[idx],       e_addr);
            check("bus_write", 32'(dbus_write[idx]), 32'(op_i[2]));
            check("bus_wstb",  32'(dbus_wstb[idx]),  32'(e_stb));
            check("bus_wdata", dbus_wdata[idx],      op_i[2] ? e_wdata : 32'd0);
            check("bus_done",  32'(done[idx]),       32'd0);
            check("bus_wen",   32'(rd_wen[idx]),     32'd0);
            obs_addr  = dbus_addr[idx];
            obs_wdata = dbus_wdata[idx];
            obs_wstb  = dbus_wstb[idx];
            if (!timed && k == waits) begin
                dbus_ready[idx] = 1'b1;
                dbus_rdata[idx] = rdata_i;
            end
            step();
            dbus_ready[idx] = 1'b0;
            dbus_rdata[idx] = $urandom;
        end

        check("post_valid", 32'(dbus_valid[idx]), 32'd0);
        if (timed) begin
            check("to_done", 32'(done[idx]),     32'd1);
            check("to_err",  32'(bus_err[idx]),  32'd1);
            check("to_mis",  32'(misalign[idx]), 32'd0);
            check("to_wen",  32'(rd_wen[idx]),   32'd0);
        end else if (op_i[2]) begin
            check("st_done", 32'(done[idx]),     32'd1);
            check("st_err",  32'(bus_err[idx]),  32'd0);
            check("st_mis",  32'(misalign[idx]), 32'd0);
            check("st_wen",  32'(rd_wen[idx]),   32'd0);
        end else begin
            check("ld_done",  32'(done[idx]),     32'd0);
            check("ld_wen",   32'(rd_wen[idx]),   32'(rd_i != 6'd0));
            check("ld_waddr", 32'(rd_waddr[idx]), 32'(rd_i));
            check("ld_wdata", rd_wdata[idx],      e_ld);
            step();
            check("ld_fdone", 32'(done[idx]),     32'd1);
            check("ld_fwen",  32'(rd_wen[idx]),   32'd0);
            check("ld_ferr",  32'(bus_err[idx]),  32'd0);
            check("ld_fmis",  32'(misalign[idx]), 32'd0);
        end
        step();
        check("end_done",  32'(done[idx]),       32'd0);
        check("end_valid", 32'(dbus_valid[idx]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            op[i]         = '0;
            op_a[i]       = '0;
            op_b[i]       = '0;
            op_c[i]       = '0;
            rd[i]         = '0;
            dbus_ready[i] = 1'b0;
            dbus_rdata[i] = '0;
        end
        obs_addr  = '0;
        obs_wdata = '0;
        obs_wstb  = '0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", 32'(dbus_valid[i]), 32'd0);
            check("rst_addr",  dbus_addr[i],       32'd0);
            check("rst_done",  32'(done[i]),       32'd0);
            check("rst_wen",   32'(rd_wen[i]),     32'd0);
            check("rst_wdata", rd_wdata[i],        32'd0);
        end
        reset = 1'b0;
        step();

        // Load word, zero-wait
        run_txn(0, 4'b0010, 32'h1000, 32'h0, 32'h4, 6'd5, 0, 32'h8000_00F0);
        check("lw_addr", obs_addr,    32'h0000_1004);
        check("lw_data", rd_wdata[0], 32'h8000_00F0);

        // Load byte signed / unsigned from lane 3
        run_txn(0, 4'b0000, 32'h1003, 32'h0, 32'h0, 6'd6, 1, 32'h8F00_0000);
        check("lb_data", rd_wdata[0], 32'hFFFF_FF8F);
        run_txn(0, 4'b1000, 32'h1003, 32'h0, 32'h0, 6'd6, 2, 32'h8F00_0000);
        check("lbu_data", rd_wdata[0], 32'h0000_008F);

        // Store half with three wait cycles
        run_txn(0, 4'b0101, 32'h2000, 32'h1234_ABCD, 32'h2, 6'd7, 3, 32'h0);
        check("sh_wstb",  32'(obs_wstb), 32'h0000_000C);
        check("sh_wdata", obs_wdata,     32'hABCD_ABCD);

        // Misaligned word load: trapped on u0, forced aligned on u1
        run_txn(0, 4'b0010, 32'h1001, 32'h0, 32'h0, 6'd8, 0, 32'h1111_2222);
        run_txn(1, 4'b0010, 32'h1001, 32'h0, 32'h0, 6'd8, 0, 32'h1111_2222);
        check("mis_off_addr", obs_addr,    32'h0000_1000);
        check("mis_off_data", rd_wdata[1], 32'h1111_2222);

        // Timeout: never ready, then ready in the final timeout cycle
        run_txn(0, 4'b0010, 32'h3000, 32'h0, 32'h0, 6'd9, 50, 32'h0);
        run_txn(0, 4'b0010, 32'h3000, 32'h0, 32'h0, 6'd9, 3, 32'hCAFE_F00D);
        check("to_last_data", rd_wdata[0], 32'hCAFE_F00D);

        // Reset while in BUS, then a normal request
        req_valid[0] = 1'b1;
        op[0]   = 4'b0010;
        op_a[0] = 32'h4000;
        op_c[0] = 32'h0;
        rd[0]   = 6'd3;
        step();
        req_valid[0] = 1'b0;
        check("rb_valid", 32'(dbus_valid[0]), 32'd1);
        step();
        reset = 1'b1;
        step();
        check("rb_rst_valid", 32'(dbus_valid[0]), 32'd0);
        check("rb_rst_done",  32'(done[0]),       32'd0);
        check("rb_rst_wen",   32'(rd_wen[0]),     32'd0);
        reset = 1'b0;
        step();
        check("rb_idle_valid", 32'(dbus_valid[0]), 32'd0);
        run_txn(0, 4'b0001, 32'h4000, 32'h0, 32'h2, 6'd4, 1, 32'h7FFF_0000);

        // Load to x0: done without a register write
        run_txn(1, 4'b0010, 32'h5000, 32'h0, 32'h0, 6'd0, 1, 32'h1234_5678);

        // Randomized traffic on both instances
        for (int n = 0; n < 40; n++) begin
            for (int idx = 0; idx < 2; idx++) begin
                run_txn(idx, 4'($urandom), $urandom, $urandom, $urandom,
                        6'($urandom_range(0, 63)),
                        (idx == 0) ? $urandom_range(0, 6) : $urandom_range(0, 5),
                        $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
